// File: rtl/ifu_fetch_ctrl_pkg.sv
// Shared constants for the IFU fetch sequencer: RV32 opcodes and widths.
package ifu_fetch_ctrl_pkg;

   localparam int         XLEN_DEF   = 32;
   localparam int         INST_W     = 32;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

endpackage

// File: rtl/ifu_fetch_ctrl_bpu.sv
// Static branch predictor: JAL always taken, conditional branches taken
// only when backward (negative offset), everything else falls through.
module ifu_fetch_ctrl_bpu
   import ifu_fetch_ctrl_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic [XLEN-1:0]   i_pc,
   input  logic [6:0]        i_opcode,
   input  logic [INST_W-1:0] i_imm,
   output logic [XLEN-1:0]   o_pred_pc
);

   logic [XLEN-1:0] w_imm_x;
   logic            w_taken;

   // Sign-extend the decoded offset to the PC width.
   assign w_imm_x = XLEN'($signed(i_imm));

   // Backward-taken / forward-not-taken decision.
   always_comb begin
      w_taken = 1'b0;
      if (i_opcode == OPC_JAL) begin
         w_taken = 1'b1;
      end else if (i_opcode == OPC_BRANCH) begin
         w_taken = i_imm[INST_W-1];
      end
   end

   assign o_pred_pc = w_taken ? (i_pc + w_imm_x) : (i_pc + XLEN'(4));

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// IFU fetch sequencer: owns the fetch PC, issues one imem request at a
// time, follows the static predictor and buffers one instruction for decode.
module ifu_fetch_ctrl
   import ifu_fetch_ctrl_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEF,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [XLEN-1:0]   imem_addr,
   input  logic              imem_ack,
   input  logic [INST_W-1:0] imem_rdata,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_pc,
   input  logic              id_ready,
   output logic              if_valid,
   output logic [INST_W-1:0] if_inst,
   output logic [XLEN-1:0]   if_pc,
   output logic [XLEN-1:0]   if_pred_pc,
   output logic              if_pred_taken
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [XLEN-1:0]   r_pc;
   logic [XLEN-1:0]   w_pc_nxt;
   logic              w_load;
   logic              w_clear;
   logic              w_slot_free;
   logic [XLEN-1:0]   w_redir_pc;
   logic [INST_W-1:0] w_imm;
   logic [XLEN-1:0]   w_pred_pc;
   logic              w_pred_taken;

   logic              r_if_valid;
   logic [INST_W-1:0] r_if_inst;
   logic [XLEN-1:0]   r_if_pc;
   logic [XLEN-1:0]   r_if_pred_pc;
   logic              r_if_pred_taken;

   assign w_slot_free  = !r_if_valid || id_ready;
   assign w_redir_pc   = redirect_pc & ~XLEN'(3);
   assign w_pred_taken = (w_pred_pc != (r_pc + XLEN'(4)));

   // Branch/jump offset extraction from the returning instruction word.
   always_comb begin
      w_imm = '0;
      case (imem_rdata[6:0])
         OPC_JAL:    w_imm = {{11{imem_rdata[31]}}, imem_rdata[31], imem_rdata[19:12],
                              imem_rdata[20], imem_rdata[30:21], 1'b0};
         OPC_BRANCH: w_imm = {{19{imem_rdata[31]}}, imem_rdata[31], imem_rdata[7],
                              imem_rdata[30:25], imem_rdata[11:8], 1'b0};
         default:    w_imm = '0;
      endcase
   end

   ifu_fetch_ctrl_bpu #(
      .XLEN (XLEN)
   ) u_bpu (
      .i_pc      (r_pc),
      .i_opcode  (imem_rdata[6:0]),
      .i_imm     (w_imm),
      .o_pred_pc (w_pred_pc)
   );

   // Next-state, next-PC and buffer load/clear decisions.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_load      = 1'b0;
      w_clear     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (redirect_valid) begin
               w_pc_nxt = w_redir_pc;
               w_clear  = 1'b1;
            end else if (w_slot_free) begin
               w_state_nxt = ST_REQ;
            end
         end
         ST_REQ: begin
            if (redirect_valid) begin
               // An ack in the redirect cycle belongs to the wrong path.
               w_pc_nxt    = w_redir_pc;
               w_clear     = 1'b1;
               w_state_nxt = imem_ack ? ST_IDLE : ST_DROP;
            end else if (imem_ack) begin
               w_load      = 1'b1;
               w_pc_nxt    = w_pred_pc;
               w_state_nxt = ST_IDLE;
            end
         end
         ST_DROP: begin
            if (redirect_valid) begin
               w_pc_nxt = w_redir_pc;
               w_clear  = 1'b1;
            end
            if (imem_ack) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // FSM state and fetch PC registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_pc    <= RESET_PC;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
      end
   end

   // One-entry decode buffer; a redirect wins over a decode accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_if_valid      <= 1'b0;
         r_if_inst       <= '0;
         r_if_pc         <= '0;
         r_if_pred_pc    <= '0;
         r_if_pred_taken <= 1'b0;
      end else if (w_clear) begin
         r_if_valid <= 1'b0;
      end else if (w_load) begin
         r_if_valid      <= 1'b1;
         r_if_inst       <= imem_rdata;
         r_if_pc         <= r_pc;
         r_if_pred_pc    <= w_pred_pc;
         r_if_pred_taken <= w_pred_taken;
      end else if (r_if_valid && id_ready) begin
         r_if_valid <= 1'b0;
      end
   end

   // REQ is only entered with a free slot, so a load never finds it full.
   always_ff @(posedge clk) begin
      if (!rst && w_load) begin
         assert (!r_if_valid);
      end
   end

   assign imem_req      = (r_state != ST_IDLE);
   assign imem_addr     = r_pc;
   assign if_valid      = r_if_valid;
   assign if_inst       = r_if_inst;
   assign if_pc         = r_if_pc;
   assign if_pred_pc    = r_if_pred_pc;
   assign if_pred_taken = r_if_pred_taken;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Scoreboard bench for ifu_fetch_ctrl: directed scenarios push expected
// request addresses and decode-side outputs; a monitor pops and compares.
module tb_ifu_fetch_ctrl;

   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam logic [31:0] JAL_M8   = 32'hFF9F_F06F;
   localparam logic [31:0] JAL_P108 = 32'h1080_006F;
   localparam logic [31:0] BEQ_P16  = 32'h0000_0863;
   localparam logic [31:0] BEQ_M16  = 32'hFE00_08E3;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] pred;
      logic        taken;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_ready;
   logic        if_valid;
   logic [31:0] if_inst;
   logic [31:0] if_pc;
   logic [31:0] if_pred_pc;
   logic        if_pred_taken;

   exp_t        q_out[$];
   logic [31:0] q_addr[$];
   int          hs_q[$];
   logic [31:0] mem[logic [31:0]];
   int          mem_delay;
   int          n_cmp;
   int          n_err;
   int          cyc;

   ifu_fetch_ctrl #(
      .XLEN     (32),
      .RESET_PC (32'h0)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_ready       (id_ready),
      .if_valid       (if_valid),
      .if_inst        (if_inst),
      .if_pc          (if_pc),
      .if_pred_pc     (if_pred_pc),
      .if_pred_taken  (if_pred_taken)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_out(input logic [31:0] inst, input logic [31:0] pc,
                          input logic [31:0] pred, input logic tk);
      exp_t e;
      e.inst  = inst;
      e.pc    = pc;
      e.pred  = pred;
      e.taken = tk;
      q_out.push_back(e);
   endtask

   function automatic logic [31:0] rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return NOP;
   endfunction

   // Memory model: acks after mem_delay waiting cycles, data from the
   // address latched when the request started.
   initial begin
      int          cnt;
      logic [31:0] lat;
      cnt        = 0;
      lat        = '0;
      imem_ack   = 1'b0;
      imem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (imem_req) begin
            if (cnt == 0) lat = imem_addr;
            if (cnt >= mem_delay) begin
               imem_ack   = 1'b1;
               imem_rdata = rd(lat);
               cnt        = 0;
            end else begin
               imem_ack   = 1'b0;
               imem_rdata = 32'hDEAD_BEEF;
               cnt++;
            end
         end else begin
            imem_ack   = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
            cnt        = 0;
         end
      end
   end

   // Monitor: decode handshakes and request starts against the queues.
   initial begin
      logic prev_req;
      exp_t e;
      prev_req = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst && if_valid && id_ready && !redirect_valid) begin
            hs_q.push_back(cyc);
            if (q_out.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_output: got pc %0h inst %0h, required none", if_pc, if_inst);
            end else begin
               e = q_out.pop_front();
               chk("out{inst,pc,pred,taken}",
                   128'({if_inst, if_pc, if_pred_pc, if_pred_taken}), 128'(e));
            end
         end
         if (imem_req && !prev_req) begin
            if (q_addr.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_request: got addr %0h, required none", imem_addr);
            end else begin
               chk("req_addr", 128'(imem_addr), 128'(q_addr.pop_front()));
            end
         end
         prev_req = imem_req;
      end
   end

   // Let the pipeline run until all expected outputs are consumed, then
   // stall decode; the one further fetch stays parked in the buffer.
   task automatic run_until_empty();
      int n;
      n = 0;
      while (q_out.size() != 0 && n < 200) begin
         tick();
         n++;
      end
      if (q_out.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain_timeout: got %0d pending outputs, required 0", q_out.size());
         q_out.delete();
      end
      id_ready = 1'b0;
      tick();
   endtask

   task automatic redirect_idle(input logic [31:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      id_ready       = 1'b1;
      tick();
      redirect_valid = 1'b0;
      chk("redir_clears_valid", 128'(if_valid), 128'(0));
      chk("redir_idle_req", 128'(imem_req), 128'(0));
   endtask

   initial begin
      n_cmp          = 0;
      n_err          = 0;
      cyc            = 0;
      mem_delay      = 0;
      rst            = 1'b1;
      id_ready       = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      mem[32'h100]   = JAL_M8;
      mem[32'h0F8]   = JAL_P108;
      mem[32'h200]   = BEQ_P16;
      mem[32'h500]   = JAL_M8;
      tick();
      tick();
      chk("rst_req", 128'(imem_req), 128'(0));
      chk("rst_addr", 128'(imem_addr), 128'(0));
      chk("rst_valid", 128'(if_valid), 128'(0));
      chk("rst_buf", 128'({if_inst, if_pc, if_pred_pc, if_pred_taken}), 128'(0));

      // Sequential ADDI stream from reset, same-cycle acks.
      q_addr.push_back(32'h0);
      q_addr.push_back(32'h4);
      q_addr.push_back(32'h8);
      q_addr.push_back(32'hC);
      exp_out(NOP, 32'h0, 32'h4, 1'b0);
      exp_out(NOP, 32'h4, 32'h8, 1'b0);
      exp_out(NOP, 32'h8, 32'hC, 1'b0);
      rst = 1'b0;
      chk("req_low_release_cycle", 128'(imem_req), 128'(0));
      tick();
      chk("req_second_cycle", 128'(imem_req), 128'(1));
      run_until_empty();
      chk("hs_count", 128'(hs_q.size()), 128'(3));
      if (hs_q.size() >= 3) begin
         chk("hs_gap01", 128'(hs_q[1] - hs_q[0]), 128'(2));
         chk("hs_gap12", 128'(hs_q[2] - hs_q[1]), 128'(2));
      end

      // Decode stall with 0xC buffered.
      exp_out(NOP, 32'hC, 32'h10, 1'b0);
      q_addr.push_back(32'h10);
      for (int i = 0; i < 5; i++) begin
         chk("stall_req", 128'(imem_req), 128'(0));
         chk("stall_buf", 128'({if_valid, if_inst, if_pc}), 128'({1'b1, NOP, 32'hC}));
         tick();
      end
      id_ready = 1'b1;
      tick();
      chk("unstall_req", 128'(imem_req), 128'(1));
      chk("unstall_addr", 128'(imem_addr), 128'(32'h10));
      id_ready = 1'b0;
      tick();

      // JAL -8 at 0x100, JAL +0x108 at 0xF8, forward branch at 0x200.
      q_addr.push_back(32'h100);
      q_addr.push_back(32'hF8);
      q_addr.push_back(32'h200);
      q_addr.push_back(32'h204);
      exp_out(JAL_M8, 32'h100, 32'hF8, 1'b1);
      exp_out(JAL_P108, 32'hF8, 32'h200, 1'b1);
      exp_out(BEQ_P16, 32'h200, 32'h204, 1'b0);
      redirect_idle(32'h100);
      run_until_empty();

      // Backward branch at 0x200.
      mem[32'h200] = BEQ_M16;
      q_addr.push_back(32'h200);
      q_addr.push_back(32'h1F0);
      exp_out(BEQ_M16, 32'h200, 32'h1F0, 1'b1);
      redirect_idle(32'h200);
      run_until_empty();

      // Slow memory, redirect while waiting: stale 0x500 data is dropped.
      mem_delay = 3;
      q_addr.push_back(32'h500);
      q_addr.push_back(32'h400);
      q_addr.push_back(32'h404);
      exp_out(NOP, 32'h400, 32'h404, 1'b0);
      redirect_idle(32'h500);
      tick();
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h403;
      tick();
      redirect_valid = 1'b0;
      chk("drop_req", 128'(imem_req), 128'(1));
      chk("drop_addr", 128'(imem_addr), 128'(32'h400));
      chk("drop_valid", 128'(if_valid), 128'(0));
      tick();
      tick();
      mem_delay = 0;
      chk("after_stale_req", 128'(imem_req), 128'(0));
      chk("after_stale_valid", 128'(if_valid), 128'(0));
      tick();
      chk("refetch_req", 128'(imem_req), 128'(1));
      chk("refetch_addr", 128'(imem_addr), 128'(32'h400));
      run_until_empty();

      // Redirect coincident with ack and id_ready, then reset during REQ.
      exp_out(NOP, 32'h404, 32'h408, 1'b0);
      q_addr.push_back(32'h408);
      q_addr.push_back(32'h600);
      id_ready = 1'b1;
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h600;
      tick();
      redirect_valid = 1'b0;
      mem_delay      = 5;
      chk("coinc_valid", 128'(if_valid), 128'(0));
      chk("coinc_idle", 128'(imem_req), 128'(0));
      tick();
      chk("coinc_req_addr", 128'({imem_req, imem_addr}), 128'({1'b1, 32'h600}));
      rst = 1'b1;
      tick();
      chk("midreq_rst_req", 128'(imem_req), 128'(0));
      chk("midreq_rst_pc", 128'(imem_addr), 128'(32'h0));
      chk("midreq_rst_valid", 128'(if_valid), 128'(0));
      rst       = 1'b0;
      mem_delay = 0;
      q_addr.push_back(32'h0);
      q_addr.push_back(32'h4);
      exp_out(NOP, 32'h0, 32'h4, 1'b0);
      run_until_empty();

      chk("out_queue_empty", 128'(q_out.size()), 128'(0));
      chk("addr_queue_empty", 128'(q_addr.size()), 128'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
